// File: rtl/bus_timer_pkg.sv
// Shared constants for the memory-mapped bus timer.
// Register word offsets, TCON bit positions and default base address.
package bus_timer_pkg;

    localparam logic [31:0] BUS_TIMER_BASE = 32'h4000_0000;

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_TPRE    = 3'd3;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: ticks when the count matches the prescale value.
// Holds while disabled; clr restarts it from zero.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] tpre,
    input  logic        clr,
    output logic        tick
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Tick detection and next prescale count
    always_comb begin
        tick = en && (pc_q == tpre);
        pc_d = pc_q;
        if (clr) begin
            pc_d = '0;
        end else if (tick) begin
            pc_d = '0;
        end else if (en) begin
            pc_d = pc_q + 16'd1;
        end
    end

    // Prescale count register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer with reload, prescaler and interrupt.
// Optional free-running counter enabled by BUS_TIMER_SYSTICK_EN.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BUS_TIMER_BASE,
    parameter logic [31:0] TH_RESET  = 32'hFFFF_FC00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;
    logic [15:0] tpre_q, tpre_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic [2:0]  off;
    logic        wr;
    logic        tick;
    logic        tl_wr;
    logic        ovf;
    logic        unused_bits;

    assign hit = (addr[31:5] == BASE_ADDR[31:5]);
    assign off = addr[4:2];
    assign wr  = Mem_wr && hit;
    assign irq = irq_q;

    assign unused_bits = ^{addr[1:0], BASE_ADDR[4:0]};

    timer_prescaler u_pre (
        .clk   (clk),
        .reset (reset),
        .en    (en_q),
        .tpre  (tpre_q),
        .clr   (wr && (off == OFF_TPRE)),
        .tick  (tick)
    );

`ifdef BUS_TIMER_SYSTICK_EN
    logic [31:0] systick_q;
    logic [31:0] systick_d;

    // Free-running cycle counter
    always_comb begin
        systick_d = systick_q + 32'd1;
    end

    // Cycle counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_d;
        end
    end
`else
    logic [31:0] systick_q;
    assign systick_q = '0;
`endif

    // Next-state: software writes, tick reload/increment, status set/clear
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        en_d   = en_q;
        ie_d   = ie_q;
        st_d   = st_q;
        tpre_d = tpre_q;
        tl_wr  = wr && (off == OFF_TL);
        ovf    = 1'b0;
        if (tick && !tl_wr) begin
            if (tl_q == 32'hFFFF_FFFF) begin
                tl_d = th_q;
                ovf  = 1'b1;
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end
        if (wr) begin
            unique case (off)
                OFF_TH:   th_d = Write_data;
                OFF_TL:   tl_d = Write_data;
                OFF_TCON: begin
                    en_d = Write_data[TCON_EN];
                    ie_d = Write_data[TCON_IE];
                    if (Write_data[TCON_ST]) begin
                        st_d = 1'b0;
                    end
                end
                OFF_TPRE: tpre_d = Write_data[15:0];
                default:  ;
            endcase
        end
        if (ovf) begin
            st_d = 1'b1;
        end
        irq_d = st_q && ie_q;
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= TH_RESET;
            tl_q   <= TH_RESET;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            st_q   <= 1'b0;
            tpre_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            st_q   <= st_d;
            tpre_q <= tpre_d;
            irq_q  <= irq_d;
        end
    end

    // Combinational read mux
    always_comb begin
        Read_data = '0;
        if (Mem_rd && hit) begin
            unique case (off)
                OFF_TH:      Read_data = th_q;
                OFF_TL:      Read_data = tl_q;
                OFF_TCON:    Read_data = {29'd0, st_q, ie_q, en_q};
                OFF_TPRE:    Read_data = {16'd0, tpre_q};
                OFF_SYSTICK: Read_data = systick_q;
                default:     Read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer.
// Covers reset, reload/irq, prescale, collisions, decode and SYSTICK.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_TPRE = BASE + 32'h0C;
    localparam logic [31:0] A_SYS  = BASE + 32'h14;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        irq;

    int checks;
    int failures;

    bus_timer dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .Mem_rd     (Mem_rd),
        .Mem_wr     (Mem_wr),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr       = a;
        Write_data = d;
        Mem_wr     = 1'b1;
        @(posedge clk);
        #1;
        Mem_wr     = 1'b0;
        Write_data = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        addr   = a;
        Mem_rd = 1'b1;
        #1;
        d      = Read_data;
        Mem_rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    logic [31:0] r;
    logic [31:0] s1;

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        addr       = '0;
        Mem_rd     = 1'b0;
        Mem_wr     = 1'b0;
        Write_data = '0;
        step(2);
        reset = 1'b0;

        // reset values
        bus_rd(A_TH, r);   chk("rst_th", r, 32'hFFFF_FC00);
        bus_rd(A_TL, r);   chk("rst_tl", r, 32'hFFFF_FC00);
        bus_rd(A_TCON, r); chk("rst_tcon", r, 32'h0);
        bus_rd(A_TPRE, r); chk("rst_tpre", r, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);

        // reload and interrupt
        bus_wr(A_TH, 32'hFFFF_FFFD);
        bus_wr(A_TL, 32'hFFFF_FFFD);
        bus_wr(A_TPRE, 32'h0);
        bus_wr(A_TCON, 32'h3);
        bus_rd(A_TL, r);   chk("rl_tl0", r, 32'hFFFF_FFFD);
        step(1);
        bus_rd(A_TL, r);   chk("rl_tl1", r, 32'hFFFF_FFFE);
        step(1);
        bus_rd(A_TL, r);   chk("rl_tl2", r, 32'hFFFF_FFFF);
        step(1);
        bus_rd(A_TL, r);   chk("rl_tl3", r, 32'hFFFF_FFFD);
        chk("rl_irq_early", {31'd0, irq}, 32'h0);
        step(1);
        bus_rd(A_TCON, r); chk("rl_tcon", r, 32'h7);
        chk("rl_irq", {31'd0, irq}, 32'h1);

        // reset mid-count leaves no status
        do_reset();
        bus_rd(A_TCON, r); chk("mid_rst_tcon", r, 32'h0);
        bus_rd(A_TL, r);   chk("mid_rst_tl", r, 32'hFFFF_FC00);
        chk("mid_rst_irq", {31'd0, irq}, 32'h0);

        // prescale by 4
        bus_wr(A_TPRE, 32'hFFFF_0003);
        bus_rd(A_TPRE, r); chk("pre_tpre", r, 32'h3);
        bus_wr(A_TL, 32'h0);
        bus_wr(A_TCON, 32'h1);
        step(3);
        bus_rd(A_TL, r);   chk("pre_tl3", r, 32'h0);
        step(1);
        bus_rd(A_TL, r);   chk("pre_tl4", r, 32'h1);
        step(4);
        bus_rd(A_TL, r);   chk("pre_tl8", r, 32'h2);

        // pause keeps prescale count
        do_reset();
        bus_wr(A_TPRE, 32'h3);
        bus_wr(A_TL, 32'h0);
        bus_wr(A_TCON, 32'h1);
        step(2);
        bus_wr(A_TCON, 32'h0);
        step(5);
        bus_rd(A_TL, r);   chk("pause_hold", r, 32'h0);
        bus_wr(A_TCON, 32'h1);
        bus_rd(A_TL, r);   chk("pause_re", r, 32'h0);
        step(1);
        bus_rd(A_TL, r);   chk("pause_tick", r, 32'h1);

        // TL write beats tick
        do_reset();
        bus_wr(A_TL, 32'h0);
        bus_wr(A_TCON, 32'h1);
        step(2);
        bus_rd(A_TL, r);   chk("col_tl_pre", r, 32'h2);
        bus_wr(A_TL, 32'h5);
        bus_rd(A_TL, r);   chk("col_tl", r, 32'h5);
        step(1);
        bus_rd(A_TL, r);   chk("col_tl_next", r, 32'h6);

        // status set beats W1C, then W1C semantics
        do_reset();
        bus_wr(A_TH, 32'hFFFF_FFFD);
        bus_wr(A_TL, 32'hFFFF_FFFD);
        bus_wr(A_TCON, 32'h3);
        step(2);
        bus_rd(A_TL, r);   chk("col_st_tl", r, 32'hFFFF_FFFF);
        bus_wr(A_TCON, 32'h7);
        bus_rd(A_TCON, r); chk("col_st", r, 32'h7);
        bus_rd(A_TL, r);   chk("col_st_rl", r, 32'hFFFF_FFFD);
        bus_wr(A_TCON, 32'h3);
        bus_rd(A_TCON, r); chk("w0_keep", r, 32'h7);
        bus_wr(A_TCON, 32'h7);
        bus_rd(A_TCON, r); chk("w1c", r, 32'h3);

        // decode
        do_reset();
        bus_rd(BASE + 32'h10, r);  chk("dec_10", r, 32'h0);
        bus_rd(BASE + 32'h1C, r);  chk("dec_1c", r, 32'h0);
        bus_rd(32'h0000_0010, r);  chk("dec_miss", r, 32'h0);
        bus_rd(BASE + 32'h06, r);  chk("dec_lowbits", r, 32'hFFFF_FC00);
        addr = A_TH;
        #1;
        chk("dec_nord", Read_data, 32'h0);
        bus_wr(BASE + 32'h10, 32'hFFFF_FFFF);
        bus_wr(32'h0000_0000, 32'h1234_5678);
        bus_wr(32'h0000_0008, 32'h3);
        bus_wr(A_SYS, 32'h0000_1234);
        bus_rd(A_TH, r);   chk("dec_th", r, 32'hFFFF_FC00);
        bus_rd(A_TL, r);   chk("dec_tl", r, 32'hFFFF_FC00);
        bus_rd(A_TCON, r); chk("dec_tcon", r, 32'h0);
        bus_rd(A_TPRE, r); chk("dec_tpre", r, 32'h0);

        // systick
        bus_rd(A_SYS, s1);
        step(10);
        bus_rd(A_SYS, r);
`ifdef BUS_TIMER_SYSTICK_EN
        chk("systick_diff", r - s1, 32'd10);
`else
        chk("systick_zero0", s1, 32'h0);
        chk("systick_zero1", r, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
